// File: rtl/render_pixel_writer.sv
// rtl/render_pixel_writer.sv - clip, linearise and queue render pixels for framebuffer writes
// Optional clipped-pixel counter: RENDER_PIXEL_WRITER_CLIP_CNT_EN
module render_pixel_writer #(
   parameter int FB_WIDTH   = 160,
   parameter int FB_HEIGHT  = 120,
   parameter int ADDR_W     = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_x,
   input  logic [7:0]        in_y,
   input  logic [7:0]        in_color,
   output logic              fb_req,
   input  logic              fb_gnt,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [7:0]        fb_data,
   output logic              busy
`ifdef RENDER_PIXEL_WRITER_CLIP_CNT_EN
   ,output logic [15:0]      clip_count
   ,input  logic [0:0]       clip_clr
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = ADDR_W + 8;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [ENT_W-1:0] head;
   logic [16:0]      addr_full;
   logic             clipped;
   logic             accept;
   logic             push;
   logic             pop;

   // Clip test and full-width linear address; the worst case 255*256+255 fits in 17 bits
   always_comb begin
      clipped   = ({1'b0, in_x} >= 9'(FB_WIDTH)) || ({1'b0, in_y} >= 9'(FB_HEIGHT));
      addr_full = {9'd0, in_y} * 17'(FB_WIDTH) + {9'd0, in_x};
   end

   assign in_ready = (count != CNT_W'(FIFO_DEPTH));
   assign fb_req   = (count != '0);
   assign busy     = fb_req;
   assign accept   = in_valid && in_ready;
   assign push     = accept && !clipped;
   assign pop      = fb_req && fb_gnt;
   assign head     = mem[rd_ptr];
   // Head is gated so stale storage never shows while empty (and reads 0 out of reset)
   assign fb_addr  = fb_req ? head[ENT_W-1:8] : '0;
   assign fb_data  = fb_req ? head[7:0] : '0;

   // FIFO storage: data only, validity comes from count
   always_ff @(posedge ACLK) begin
      if (push) begin
         mem[wr_ptr] <= {ADDR_W'(addr_full), in_color};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef RENDER_PIXEL_WRITER_CLIP_CNT_EN
   // Saturating count of clipped transfers; clear wins over a same-cycle increment
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         clip_count <= '0;
      end else if (clip_clr[0]) begin
         clip_count <= '0;
      end else if (accept && clipped && (clip_count != 16'hFFFF)) begin
         clip_count <= clip_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_render_pixel_writer.sv
// tb/tb_render_pixel_writer.sv - directed self-checking bench for render_pixel_writer
module tb_render_pixel_writer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_x;
   logic [7:0]  in_y;
   logic [7:0]  in_color;
   logic        fb_req;
   logic        fb_gnt;
   logic [14:0] fb_addr;
   logic [7:0]  fb_data;
   logic        busy;
`ifdef RENDER_PIXEL_WRITER_CLIP_CNT_EN
   logic [15:0] clip_count;
   logic [0:0]  clip_clr;
`endif

   int checks = 0;
   int errors = 0;
   int req_hi = 0;

   logic [22:0] wq[$];
   logic [22:0] exq[$];

   logic        prev_req = 1'b0;
   logic        prev_gnt = 1'b0;
   logic [14:0] prev_addr = '0;
   logic [7:0]  prev_data = '0;

   render_pixel_writer dut (
      .ACLK      (clk),
      .ARESETn   (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_color  (in_color),
      .fb_req    (fb_req),
      .fb_gnt    (fb_gnt),
      .fb_addr   (fb_addr),
      .fb_data   (fb_data),
      .busy      (busy)
`ifdef RENDER_PIXEL_WRITER_CLIP_CNT_EN
      ,.clip_count(clip_count)
      ,.clip_clr  (clip_clr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [22:0] ent(input int x, input int y, input int c);
      logic [14:0] a;
      a = 15'(y * 160 + x);
      return {a, 8'(c)};
   endfunction

   // Write monitor: records granted writes and checks request hold during stalls
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0;
      end else begin
         if (prev_req && !prev_gnt) begin
            check("hold_req", {31'd0, fb_req}, 32'd1);
            check("hold_addr", {17'd0, fb_addr}, {17'd0, prev_addr});
            check("hold_data", {24'd0, fb_data}, {24'd0, prev_data});
         end
         if (fb_req) req_hi++;
         if (fb_req && fb_gnt) wq.push_back({fb_addr, fb_data});
         prev_req  = fb_req;
         prev_gnt  = fb_gnt;
         prev_addr = fb_addr;
         prev_data = fb_data;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Hold a pixel on the input until it is accepted (bounded)
   task automatic send(input int x, input int y, input int c);
      logic r;
      logic done;
      done = 1'b0;
      in_valid = 1'b1;
      in_x = 8'(x);
      in_y = 8'(y);
      in_color = 8'(c);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         r = in_ready;
         cyc();
         if (r) begin
            done = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      check("send_accepted", {31'd0, done}, 32'd1);
      if (done && x < 160 && y < 120) exq.push_back(ent(x, y, c));
   endtask

   task automatic drain();
      logic idle;
      idle = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy) begin
            idle = 1'b1;
            break;
         end
      end
      check("drain_idle", {31'd0, idle}, 32'd1);
      cyc();
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_count"}, wq.size(), exq.size());
      for (int i = 0; i < exq.size(); i++) begin
         if (i < wq.size()) check({tag, "_entry"}, {9'd0, wq[i]}, {9'd0, exq[i]});
      end
      wq.delete();
      exq.delete();
   endtask

   initial begin
      rst_n = 1'b1;
      in_valid = 1'b0;
      in_x = '0;
      in_y = '0;
      in_color = '0;
      fb_gnt = 1'b0;
`ifdef RENDER_PIXEL_WRITER_CLIP_CNT_EN
      clip_clr = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_fb_req", {31'd0, fb_req}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_fb_addr", {17'd0, fb_addr}, 32'd0);
      check("rst_fb_data", {24'd0, fb_data}, 32'd0);
`ifdef RENDER_PIXEL_WRITER_CLIP_CNT_EN
      check("rst_clip_count", {16'd0, clip_count}, 32'd0);
`endif
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();

      // Single pixel with grant held high
      fb_gnt = 1'b1;
      req_hi = 0;
      send(10, 2, 8'h3C);
      @(negedge clk);
      check("single_req", {31'd0, fb_req}, 32'd1);
      check("single_addr", {17'd0, fb_addr}, 32'd330);
      check("single_data", {24'd0, fb_data}, 32'h3C);
      @(negedge clk);
      check("single_req_drop", {31'd0, fb_req}, 32'd0);
      cyc();
      check("single_req_cycles", req_hi, 32'd1);
      compare_writes("single");

      // Corner and clipped pixels
      send(159, 119, 8'h11);
      send(160, 0, 8'h22);
      send(0, 120, 8'h33);
      drain();
      check("corner_addr", {9'd0, exq.size() > 0 ? exq[0] : 23'd0}, {9'd0, 15'd19199, 8'h11});
      compare_writes("clip");
`ifdef RENDER_PIXEL_WRITER_CLIP_CNT_EN
      check("clip_count", {16'd0, clip_count}, 32'd2);
      clip_clr = 1'b1;
      cyc();
      clip_clr = 1'b0;
      check("clip_clear", {16'd0, clip_count}, 32'd0);
`endif

      // Backpressure: six pixels offered with no grant
      fb_gnt = 1'b0;
      for (int k = 0; k < 6; k++) begin
         logic acc;
         in_valid = 1'b1;
         in_x = 8'(k * 3);
         in_y = 8'(k + 1);
         in_color = 8'(8'hA0 + k);
         @(negedge clk);
         acc = in_ready;
         check("bp_ready", {31'd0, acc}, {31'd0, k < 4});
         if (acc) exq.push_back(ent(k * 3, k + 1, 8'hA0 + k));
         cyc();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_head_addr", {17'd0, fb_addr}, 32'd160);
      check("bp_head_data", {24'd0, fb_data}, 32'hA0);
      cyc();
      fb_gnt = 1'b1;
      @(negedge clk);
      check("bp_ready_at_grant", {31'd0, in_ready}, 32'd0);
      cyc();
      @(negedge clk);
      check("bp_ready_after_grant", {31'd0, in_ready}, 32'd1);
      cyc();
      send(12, 5, 8'hA4);
      send(15, 6, 8'hA5);
      drain();
      compare_writes("bp");

      // Simultaneous push and pop at count 2
      fb_gnt = 1'b0;
      send(1, 1, 8'h51);
      send(2, 2, 8'h52);
      fb_gnt = 1'b1;
      send(3, 3, 8'h53);
      fb_gnt = 1'b0;
      @(negedge clk);
      check("pp_count", {29'd0, dut.count}, 32'd2);
      check("pp_head_addr", {17'd0, fb_addr}, 32'd322);
      cyc();
      fb_gnt = 1'b1;
      drain();
      compare_writes("pp");

      // Streaming 32 pixels with grant high
      req_hi = 0;
      for (int k = 0; k < 32; k++) send(k * 5, k, k);
      @(negedge clk);
      check("stream_last_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("stream_busy_fall", {31'd0, busy}, 32'd0);
      cyc();
      check("stream_req_cycles", req_hi, 32'd32);
      compare_writes("stream");

      // Reset with three pixels buffered
      fb_gnt = 1'b0;
      send(7, 7, 8'h71);
      send(8, 8, 8'h72);
      send(9, 9, 8'h73);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_fb_req", {31'd0, fb_req}, 32'd0);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
      exq.delete();
      cyc();
      cyc();
      rst_n = 1'b1;
      fb_gnt = 1'b1;
      repeat (5) cyc();
      check("mrst_no_req", {31'd0, fb_req}, 32'd0);
      compare_writes("mrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
